// File: rtl/xcache_ctrl_assoc.sv
// rtl/xcache_ctrl_assoc.sv - WAYS-way cache controller FSM: lookup, writeback, pipelined line fill, write-merge
module xcache_ctrl_assoc #(
    parameter int WAYS    = 2,
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_rd,
    input  logic                     req_wr,
    input  logic [WAYS-1:0]          hit,
    input  logic [WAYS-1:0]          valid,
    input  logic [WAYS-1:0]          dirty,
    input  logic                     cache_err,
    input  logic                     mem_err,
    input  logic                     mem_stall,
    output logic                     comp,
    output logic                     cache_wr,
    output logic [WAYS-1:0]          way_sel,
    output logic [$clog2(WORDS)-1:0] word_sel,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [$clog2(WORDS)-1:0] mem_word,
    output logic                     stall,
    output logic                     done,
    output logic                     hit_out,
    output logic                     err
);
    localparam int WW = $clog2(WORDS);
    localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WW-1:0] LAST = WW'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, HIT, WB, FILL, MERGE, DONE, ERR} state_t;

    state_t              state;
    logic                is_wr;
    logic [WAYS-1:0]     hit_way;
    logic [WAYS-1:0]     victim;
    logic [PW-1:0]       victim_ptr;
    logic [WW-1:0]       wb_cnt;
    logic [WW-1:0]       rd_cnt;
    logic [WW-1:0]       ret_cnt;
    logic                rd_all;
    logic [MEM_LAT-1:0]  pipe;

    logic [WAYS-1:0]     hv;
    logic [WAYS-1:0]     hit_oh;
    logic [WAYS-1:0]     inv_oh;
    logic [WAYS-1:0]     vic_oh;
    logic                vic_dirty;
    logic                issue;
    logic                install;
    logic                fault;

    // Downward scans so the lowest-index way wins both the hit and invalid-victim choice.
    always_comb begin
        hv     = hit & valid;
        hit_oh = '0;
        inv_oh = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hv[i])
                hit_oh = WAYS'(1) << i;
            if (!valid[i])
                inv_oh = WAYS'(1) << i;
        end
        vic_oh    = (inv_oh != '0) ? inv_oh : (WAYS'(1) << victim_ptr);
        vic_dirty = |(vic_oh & valid & dirty);
    end

    assign issue   = (state == FILL) && !rd_all && !mem_stall;
    assign install = pipe[MEM_LAT-1];
    assign fault   = cache_err | mem_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            is_wr      <= 1'b0;
            hit_way    <= '0;
            victim     <= '0;
            victim_ptr <= '0;
            wb_cnt     <= '0;
            rd_cnt     <= '0;
            ret_cnt    <= '0;
            rd_all     <= 1'b0;
            pipe       <= '0;
        end else begin
            pipe <= (pipe << 1) | MEM_LAT'(issue);
            case (state)
                IDLE: begin
                    if (req_rd || req_wr) begin
                        is_wr <= req_wr;
                        if (req_rd && req_wr) begin
                            state <= ERR;
                        end else if (hv != '0) begin
                            hit_way <= hit_oh;
                            state   <= HIT;
                        end else begin
                            victim <= vic_oh;
                            state  <= vic_dirty ? WB : FILL;
                        end
                    end
                end
                HIT: state <= IDLE;
                WB: begin
                    if (!mem_stall) begin
                        wb_cnt <= wb_cnt + 1'b1;
                        if (wb_cnt == LAST)
                            state <= FILL;
                    end
                end
                FILL: begin
                    if (issue) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST)
                            rd_all <= 1'b1;
                    end
                    if (install) begin
                        ret_cnt <= ret_cnt + 1'b1;
                        if (ret_cnt == LAST) begin
                            rd_all     <= 1'b0;
                            victim_ptr <= (victim_ptr == PW'(WAYS - 1)) ? '0 : victim_ptr + 1'b1;
                            state      <= is_wr ? MERGE : DONE;
                        end
                    end
                end
                MERGE:   state <= DONE;
                default: state <= IDLE;
            endcase
            // Errors abort the operation: drop in-flight returns so nothing installs afterwards.
            if (fault && (state == HIT || state == WB || state == FILL || state == MERGE)) begin
                state   <= ERR;
                pipe    <= '0;
                wb_cnt  <= '0;
                rd_cnt  <= '0;
                ret_cnt <= '0;
                rd_all  <= 1'b0;
            end
        end
    end

    always_comb begin
        comp     = 1'b0;
        cache_wr = 1'b0;
        way_sel  = '0;
        word_sel = '0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_word = '0;
        stall    = 1'b0;
        done     = 1'b0;
        hit_out  = 1'b0;
        err      = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    comp  = req_rd | req_wr;
                    stall = (req_rd | req_wr) && ((req_rd && req_wr) || (hv == '0));
                end
                HIT: begin
                    done     = 1'b1;
                    hit_out  = 1'b1;
                    way_sel  = hit_way;
                    comp     = is_wr;
                    cache_wr = is_wr;
                end
                WB: begin
                    stall    = 1'b1;
                    way_sel  = victim;
                    word_sel = wb_cnt;
                    mem_word = wb_cnt;
                    mem_wr   = !mem_stall;
                end
                FILL: begin
                    stall    = 1'b1;
                    way_sel  = victim;
                    mem_rd   = issue;
                    mem_word = rd_cnt;
                    cache_wr = install;
                    word_sel = ret_cnt;
                end
                MERGE: begin
                    stall    = 1'b1;
                    comp     = 1'b1;
                    cache_wr = 1'b1;
                    way_sel  = victim;
                end
                DONE: done = 1'b1;
                ERR: begin
                    done = 1'b1;
                    err  = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_xcache_ctrl_assoc.sv
// tb/tb_xcache_ctrl_assoc.sv - directed + random bench for xcache_ctrl_assoc against a transaction-level model
module tb_xcache_ctrl_assoc;
    localparam int MEM_LAT = 4;

    logic       clk, rst, req_rd, req_wr, cache_err, mem_err, mem_stall;
    logic [1:0] hit, valid, dirty;
    logic       comp, cache_wr, mem_rd, mem_wr, stall, done, hit_out, err;
    logic [1:0] way_sel, word_sel, mem_word;

    int checks = 0;
    int errors = 0;
    int mdl_ptr = 0;

    xcache_ctrl_assoc #(.WAYS(2), .WORDS(4), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .hit(hit), .valid(valid),
        .dirty(dirty), .cache_err(cache_err), .mem_err(mem_err), .mem_stall(mem_stall),
        .comp(comp), .cache_wr(cache_wr), .way_sel(way_sel), .word_sel(word_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_word(mem_word), .stall(stall),
        .done(done), .hit_out(hit_out), .err(err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {17'd0, comp, cache_wr, way_sel, word_sel, mem_rd, mem_wr, mem_word, stall, done, hit_out, err};
    endfunction

    // stall_mode: 0 none, 1 random, 2 mem_stall in cycles 2..4
    task automatic run_txn(input string name, input bit rd, input bit wr, input logic [1:0] v,
                           input logic [1:0] d, input logic [1:0] h, input int err_at, input int stall_mode);
        int sp[0:127];
        int ewc[$], erc[$], eic[$];
        int owc[$], oww[$], owy[$], orc[$], orw[$], oic[$], oiw[$], oiy[$];
        int done_c, exp_hit, exp_err, exp_way, exp_merge, exp_st0, vict, c;
        int obs_done_c, obs_hit, obs_err, obs_way, obs_merge, obs_st0;
        logic [1:0] hv;
        for (int i = 0; i < 128; i++)
            sp[i] = (stall_mode == 1) ? int'($urandom_range(0, 2) == 0) : int'(stall_mode == 2 && i >= 2 && i <= 4);
        hv = h & v;
        exp_hit = 0; exp_err = 0; exp_way = 0; exp_merge = -1; exp_st0 = 1;
        if (rd && wr) begin
            done_c = 1; exp_err = 1;
        end else if (hv != 2'b00) begin
            done_c = 1; exp_hit = 1; exp_st0 = 0;
            exp_way = hv[0] ? 1 : 2;
            exp_merge = wr ? 1 : -1;
        end else begin
            vict = !v[0] ? 0 : (!v[1] ? 1 : mdl_ptr);
            exp_way = 1 << vict;
            c = 1;
            if (v[vict] && d[vict])
                for (int w = 0; w < 4; w++) begin
                    while (c < 120 && sp[c] != 0) c++;
                    ewc.push_back(c); c++;
                end
            for (int w = 0; w < 4; w++) begin
                while (c < 120 && sp[c] != 0) c++;
                erc.push_back(c); c++;
            end
            done_c = erc[3] + MEM_LAT + 1 + (wr ? 1 : 0);
            exp_merge = wr ? done_c - 1 : -1;
            if (err_at > 0) begin
                done_c = err_at + 1; exp_err = 1; exp_merge = -1;
                while (ewc.size() > 0 && ewc[ewc.size()-1] > err_at) void'(ewc.pop_back());
                while (erc.size() > 0 && erc[erc.size()-1] > err_at) void'(erc.pop_back());
            end else begin
                mdl_ptr = (mdl_ptr + 1) % 2;
            end
            foreach (erc[i])
                if (err_at <= 0 || erc[i] + MEM_LAT <= err_at) eic.push_back(erc[i] + MEM_LAT);
        end

        obs_done_c = -1; obs_hit = 0; obs_err = 0; obs_way = 0; obs_merge = -1; obs_st0 = 0;
        for (int cy = 0; cy < 120 && obs_done_c < 0; cy++) begin
            @(negedge clk);
            req_rd = rd; req_wr = wr; valid = v; dirty = d; hit = h;
            mem_stall = sp[cy] != 0;
            mem_err = (cy == err_at);
            #1;
            if (cy == 0) obs_st0 = stall;
            if (mem_rd && mem_wr) chk({name, " rd_wr_excl"}, 1, 0);
            if (mem_wr) begin owc.push_back(cy); oww.push_back(mem_word); owy.push_back(way_sel); end
            if (mem_rd) begin orc.push_back(cy); orw.push_back(mem_word); end
            if (cache_wr && !comp) begin oic.push_back(cy); oiw.push_back(word_sel); oiy.push_back(way_sel); end
            if (cache_wr && comp) obs_merge = cy;
            if (done) begin
                obs_done_c = cy; obs_hit = hit_out; obs_err = err; obs_way = way_sel;
            end
        end
        chk({name, " done_cycle"}, obs_done_c, done_c);
        chk({name, " hit_out"}, obs_hit, exp_hit);
        chk({name, " err"}, obs_err, exp_err);
        chk({name, " stall_c0"}, obs_st0, exp_st0);
        chk({name, " merge_cycle"}, obs_merge, exp_merge);
        if (exp_hit != 0) chk({name, " hit_way"}, obs_way, exp_way);
        chk({name, " n_mem_wr"}, owc.size(), ewc.size());
        chk({name, " n_mem_rd"}, orc.size(), erc.size());
        chk({name, " n_install"}, oic.size(), eic.size());
        foreach (ewc[i]) if (i < owc.size()) begin
            chk({name, " wr_cycle"}, owc[i], ewc[i]);
            chk({name, " wr_word"}, oww[i], i);
            chk({name, " wr_way"}, owy[i], exp_way);
        end
        foreach (erc[i]) if (i < orc.size()) begin
            chk({name, " rd_cycle"}, orc[i], erc[i]);
            chk({name, " rd_word"}, orw[i], i);
        end
        foreach (eic[i]) if (i < oic.size()) begin
            chk({name, " inst_cycle"}, oic[i], eic[i]);
            chk({name, " inst_word"}, oiw[i], i);
            chk({name, " inst_way"}, oiy[i], exp_way);
        end
        @(negedge clk);
        req_rd = 0; req_wr = 0; mem_err = 0; mem_stall = 0; hit = 0;
        #1;
        chk({name, " idle_outputs"}, all_out(), 0);
    endtask

    initial begin
        bit found;
        rst = 0; req_rd = 1; req_wr = 0; hit = 0; valid = 0; dirty = 0;
        cache_err = 0; mem_err = 0; mem_stall = 0;
        #12;
        chk("reset_outputs", all_out(), 0);
        @(negedge clk);
        req_rd = 0;
        rst = 1;

        run_txn("t1_hit", 1, 0, 2'b11, 2'b00, 2'b10, -1, 0);
        run_txn("t3_dirty_wb", 1, 0, 2'b11, 2'b11, 2'b00, -1, 0);
        run_txn("t3_next_way1", 1, 0, 2'b11, 2'b11, 2'b00, -1, 0);
        run_txn("t2_wr_miss", 0, 1, 2'b01, 2'b00, 2'b00, -1, 0);
        run_txn("t4_stalled", 0, 1, 2'b01, 2'b00, 2'b00, -1, 2);
        run_txn("t5_mem_err", 0, 1, 2'b01, 2'b00, 2'b00, 3, 0);
        run_txn("both_req", 1, 1, 2'b11, 2'b00, 2'b01, -1, 0);
        run_txn("hit_write", 0, 1, 2'b11, 2'b01, 2'b11, -1, 0);

        found = 0;
        @(negedge clk);
        req_rd = 1; valid = 2'b11; dirty = 2'b11; hit = 2'b00;
        for (int cy = 0; cy < 20 && !found; cy++) begin
            #1;
            if (mem_wr && mem_word == 2'd2) found = 1;
            else @(negedge clk);
        end
        chk("t6_reached_wb2", found, 1);
        rst = 0;
        #1;
        chk("t6_reset_outputs", all_out(), 0);
        @(negedge clk);
        rst = 1; req_rd = 0;
        mdl_ptr = 0;
        run_txn("t6_hit_after_rst", 1, 0, 2'b01, 2'b00, 2'b01, -1, 0);

        for (int n = 0; n < 24; n++) begin
            bit r, w;
            r = 1'($urandom_range(0, 1));
            w = !r;
            if ($urandom_range(0, 9) == 0) begin r = 1; w = 1; end
            run_txn("rand", r, w, 2'($urandom), 2'($urandom), 2'($urandom), -1, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
